// File: rtl/updown_counter.sv
// rtl/updown_counter.sv - parametrised up/down counter with prescaler, load/clear and terminal-count pulse
module updown_counter #(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter int SATURATE  = 0,
    parameter int PRESCALE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear,
    output logic [WIDTH-1:0] out,
    output logic             tc
);

    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] out_q, out_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] load_clamped;

    // A full-range counter cannot receive an out-of-range load, so no comparator is built
    generate
        if (MAX_COUNT == 2**WIDTH - 1) begin : g_no_clamp
            assign load_clamped = load_value;
        end else begin : g_clamp
            assign load_clamped = (load_value > MAX_V) ? MAX_V : load_value;
        end
    endgenerate

    always_comb begin
        out_d = out_q;
        pre_d = pre_q;
        tc_d  = 1'b0;
        if (clear) begin
            out_d = '0;
            pre_d = '0;
        end else if (load) begin
            out_d = load_clamped;
            pre_d = '0;
        end else if (enable) begin
            if (pre_q != PRE_LAST) begin
                pre_d = pre_q + 1'b1;
            end else begin
                pre_d = '0;
                if (up) begin
                    if (out_q == MAX_V) begin
                        tc_d  = 1'b1;
                        out_d = (SATURATE != 0) ? MAX_V : '0;
                    end else begin
                        out_d = out_q + 1'b1;
                    end
                end else begin
                    if (out_q == '0) begin
                        tc_d  = 1'b1;
                        out_d = (SATURATE != 0) ? '0 : MAX_V;
                    end else begin
                        out_d = out_q - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= '0;
            pre_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            out_q <= out_d;
            pre_q <= pre_d;
            tc_q  <= tc_d;
        end
    end

    assign out = out_q;
    assign tc  = tc_q;

endmodule

// File: tb/tb_updown_counter.sv
// tb/tb_updown_counter.sv - scoreboard bench driving five counter configurations with shared stimulus
module tb_updown_counter;

    localparam int N = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       up;
    logic       load;
    logic [7:0] load_value;
    logic       clear;
    logic [7:0] out_w [N];
    logic       tc_w  [N];

    // Configurations: default, mod-10 wrap, mod-6 saturate, prescale 3, mod-10 saturate prescale 3
    int p_max [N] = '{255, 9, 5, 255, 9};
    int p_sat [N] = '{0, 0, 1, 0, 1};
    int p_pre [N] = '{1, 1, 1, 3, 3};

    int m_out [N];
    int m_pre [N];
    int m_tc  [N];

    logic [N-1:0][8:0] exp_q [$];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    updown_counter #(.WIDTH(8)) u0 (
        .clk(clk), .reset(rst_n), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .clear(clear), .out(out_w[0]), .tc(tc_w[0]));
    updown_counter #(.WIDTH(8), .MAX_COUNT(9)) u1 (
        .clk(clk), .reset(rst_n), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .clear(clear), .out(out_w[1]), .tc(tc_w[1]));
    updown_counter #(.WIDTH(8), .MAX_COUNT(5), .SATURATE(1)) u2 (
        .clk(clk), .reset(rst_n), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .clear(clear), .out(out_w[2]), .tc(tc_w[2]));
    updown_counter #(.WIDTH(8), .PRESCALE(3)) u3 (
        .clk(clk), .reset(rst_n), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .clear(clear), .out(out_w[3]), .tc(tc_w[3]));
    updown_counter #(.WIDTH(8), .MAX_COUNT(9), .SATURATE(1), .PRESCALE(3)) u4 (
        .clk(clk), .reset(rst_n), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .clear(clear), .out(out_w[4]), .tc(tc_w[4]));

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s[%0d] at %0t: got %0d expected %0d", name, idx, $time, act, exp);
        end
    endtask

    // Reference model: count range treated as a ring of MAX+1 values, prescaler as a phase counter
    task automatic model_step(input logic r, input logic en, input logic u,
                              input logic ld, input int lv, input logic cl);
        logic [N-1:0][8:0] e;
        for (int i = 0; i < N; i++) begin
            int range;
            int nxt;
            bit boundary;
            range   = p_max[i] + 1;
            m_tc[i] = 0;
            if (!r) begin
                m_out[i] = 0;
                m_pre[i] = 0;
            end else if (cl) begin
                m_out[i] = 0;
                m_pre[i] = 0;
            end else if (ld) begin
                m_out[i] = (lv > p_max[i]) ? p_max[i] : lv;
                m_pre[i] = 0;
            end else if (en) begin
                m_pre[i] = (m_pre[i] + 1) % p_pre[i];
                if (m_pre[i] == 0) begin
                    nxt      = u ? (m_out[i] + 1) % range : (m_out[i] + range - 1) % range;
                    boundary = u ? (m_out[i] == p_max[i]) : (m_out[i] == 0);
                    m_tc[i]  = boundary ? 1 : 0;
                    if (!(boundary && p_sat[i] != 0))
                        m_out[i] = nxt;
                end
            end
            e[i] = {m_out[i][7:0], m_tc[i][0]};
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic en, input logic u,
                       input logic ld, input logic [7:0] lv, input logic cl);
        rst_n      = r;
        enable     = en;
        up         = u;
        load       = ld;
        load_value = lv;
        clear      = cl;
        model_step(r, en, u, ld, int'(lv), cl);
        @(negedge clk);
    endtask

    initial begin : monitor
        logic [N-1:0][8:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < N; i++) begin
                    chk("out", i, int'(out_w[i]), int'(e[i][8:1]));
                    chk("tc", i, int'(tc_w[i]), int'(e[i][0]));
                end
            end
        end
    end

    initial begin : driver
        bit en_pat [8] = '{1, 1, 0, 0, 1, 1, 1, 1};
        logic r_up;
        for (int i = 0; i < N; i++) begin
            m_out[i] = 0;
            m_pre[i] = 0;
            m_tc[i]  = 0;
        end

        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
        for (int k = 0; k < 260; k++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);

        cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0);
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);

        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'd4, 1'b0);
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);

        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
        for (int k = 0; k < 8; k++) cyc(1'b1, en_pat[k], 1'b1, 1'b0, 8'd0, 1'b0);

        cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'd200, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'd4, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);

        // Count up, then drop reset between edges and check the outputs clear without a clock
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
        for (int k = 0; k < 37; k++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            chk("async_out", i, int'(out_w[i]), 0);
            chk("async_tc", i, int'(tc_w[i]), 0);
        end
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);

        r_up = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 15) == 0) r_up = ~r_up;
            cyc(($urandom_range(0, 199) != 0),
                ($urandom_range(0, 9) < 7),
                r_up,
                ($urandom_range(0, 19) == 0),
                8'($urandom_range(0, 255)),
                ($urandom_range(0, 29) == 0));
        end

        @(posedge clk);
        #2;
        chk("drain", 0, exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised up/down counter, the successor to the fixed 8-bit free-running counter. It adds configurable width and modulus, direction control, synchronous clear and load, an enable prescaler, and selectable wrap or saturate behaviour. A registered terminal-count pulse marks each boundary event. It sits in the same timing and test infrastructure as the existing counter and serves as the general counting primitive for timers, address generators and event counters.

## Interface
- `WIDTH`, 8: width of `out` and `load_value`; minimum 1.
- `MAX_COUNT`, 2**WIDTH-1: top of the count range. The count range is 0..MAX_COUNT. Requires 1 <= MAX_COUNT <= 2**WIDTH-1.
- `SATURATE`, 0:
  - 0: wrap at the boundaries.
  - 1: hold at the boundaries.
- `PRESCALE`, 1: number of enabled cycles per count step; minimum 1.

Ports:
- `clk`  in  1  rising-edge clock. This is the only clock.
- `reset`  in  1  asynchronous, active-low reset. Assertion takes effect immediately. Deassertion is synchronous to `clk` by the integrator.
- `enable`  in  1  qualifies prescaler advance and counting.
- `up`  in  1  direction: 1 = increment, 0 = decrement. Sampled on step cycles only.
- `load`  in  1  synchronous load of `load_value`.
- `load_value`  in  WIDTH  value to load.
- `clear`  in  1  synchronous clear to 0.
- `out`  out  WIDTH  current count (registered).
- `tc`  out  1  registered terminal-count pulse.

## Operation
- Internal prescaler register `pre` counts 0..PRESCALE-1. With PRESCALE=1 it is constant 0 and every enabled cycle is a step.
- A step cycle is one where `enable`=1 and `pre`=PRESCALE-1 and neither `clear` nor `load` is active.
- Per-edge priority is clear > load > enable > hold:
  - **clear=1:** out←0, pre←0, tc←0. Independent of `enable`.
  - **load=1:**
    - out←min(load_value, MAX_COUNT), pre←0, tc←0. Independent of `enable`.
    - Out-of-range loads clamp to MAX_COUNT. They never produce an out-of-range count.
  - **enable=1, not a step cycle:** pre←pre+1; out unchanged; tc←0.
  - **step cycle:** pre←0, then:
    - up=1, out<MAX_COUNT: out←out+1, tc←0.
    - up=1, out=MAX_COUNT: out←0 (SATURATE=0) or out unchanged (SATURATE=1); tc←1.
    - up=0, out>0: out←out-1, tc←0.
    - up=0, out=0: out←MAX_COUNT (SATURATE=0) or out unchanged (SATURATE=1); tc←1.
  - **enable=0:** out and pre hold; tc←0.
- In saturate mode, `tc` pulses on every attempted step at the boundary. The count holding at MAX_COUNT with `enable` high and `up`=1 therefore produces `tc` high once per step.
- Arithmetic is modulo the range 0..MAX_COUNT, never modulo 2**WIDTH. For non-power-of-two MAX_COUNT, the value MAX_COUNT+1 never appears on `out`.

## Timing
- Reset values: out=0, tc=0, pre=0.
- Latency from a sampled `enable`/`load`/`clear` to `out` is 1 clock edge.
- `tc` is high for the single cycle in which `out` shows the wrapped (or held) value. It is low on every other cycle.
- With PRESCALE=P and `enable` held high, `out` changes once every P cycles. The first change after reset, clear or load occurs at the P-th enabled edge.
- Dropping `enable` freezes `pre`; the prescale phase resumes where it stopped.
- A direction change takes effect on the next step cycle and does not reset `pre`.
- Reset asserted mid-count clears all state asynchronously, regardless of `clk`.
- A `load` or `clear` in the same cycle as a would-be boundary step suppresses `tc`.

## Test plan
- **Reset and free-run:**
  - Stimulus: WIDTH=8, defaults; reset low 3 cycles, then high; enable=1, up=1 for 260 cycles.
  - Response: out=0 during reset; 0→255 counting; out=0 with tc=1 on cycle 256; tc low on all other cycles.
- **Modulus wrap down:**
  - Stimulus: MAX_COUNT=9; load 2, then up=0, enable=1.
  - Response: out sequence 2,1,0,9,8. tc=1 exactly while out=9.
- **Saturate:**
  - Stimulus: SATURATE=1, MAX_COUNT=5; load 4, up=1, enable=1 for 4 cycles.
  - Response: out 5,5,5,5; tc 0,1,1,1.
- **Prescaler and enable gap:**
  - Stimulus: PRESCALE=3; enable pattern 1,1,0,0,1,1,1,1.
  - Response: out 0→1 at the 3rd enabled edge, 1→2 at the 6th. No change while enable=0.
- **Priority and clamp:**
  - Stimulus: MAX_COUNT=9; load=1 with load_value=200, then clear=1 and load=1 together with load_value=4.
  - Response: out=9, then out=0; tc=0 throughout.
- **Async reset mid-operation:**
  - Stimulus: count to 37; assert reset between clock edges.
  - Response: out=0 and tc=0 before the next rising edge; counting restarts from 0 after release.
